// File: rtl/mem_wb_stage_if.sv
//------------------------------------------------------------------------------
// Module   : mem_wb_stage_if
// Brief    : Data-memory req/ready + rvalid bus between mem_wb_stage and DMEM.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_wb_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rvalid, rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_wb_stage.sv
//------------------------------------------------------------------------------
// Module   : mem_wb_stage
// Brief    : EX/WB consumer: regfile writeback or DMEM load/store with timeout.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_wb_stage #(
  parameter int DMEM_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [31:0] wb_result,
  input  wire logic [31:0] wb_mem_addr,
  input  wire logic        wb_mem_write,
  input  wire logic        wb_mem_to_reg,
  input  wire logic        wb_alu_to_reg,
  input  wire logic [4:0]  wb_dest_reg_sel,
  input  wire logic [2:0]  mem_alu_operation,
  mem_wb_stage_if.master   dmem,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             stall_read,
  output logic             misalign_err,
  output logic             bus_err
);

  localparam bit             c_TO_EN   = (DMEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(DMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic        w_store, w_load, w_mem_op;
  logic        w_is_byte, w_is_half, w_is_word, w_unsigned;
  logic        w_misalign, w_timeout, w_rd_nz;
  logic [1:0]  w_off;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata, w_ldata;
  logic [7:0]  w_lbyte;
  logic [15:0] w_lhalf;

  // Store outranks load when both are flagged.
  assign w_store    = wb_mem_write;
  assign w_load     = wb_mem_to_reg & ~wb_mem_write;
  assign w_mem_op   = w_store | w_load;
  assign w_is_byte  = (mem_alu_operation[1:0] == 2'b00);
  assign w_is_half  = (mem_alu_operation[1:0] == 2'b01);
  assign w_is_word  = ~w_is_byte & ~w_is_half;
  assign w_unsigned = mem_alu_operation[2];
  assign w_off      = wb_mem_addr[1:0];
  assign w_rd_nz    = (wb_dest_reg_sel != 5'd0);
  assign w_misalign = (w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00));
  assign w_timeout  = c_TO_EN && (r_cnt == c_TO_LAST);

  assign dmem.addr  = {wb_mem_addr[31:2], 2'b00};
  assign dmem.wdata = w_st_wdata;

  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = wb_result;
    if (w_is_byte) begin
      w_st_be    = 4'b0001 << w_off;
      w_st_wdata = {4{wb_result[7:0]}};
    end else if (w_is_half) begin
      w_st_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_st_wdata = {2{wb_result[15:0]}};
    end
  end

  assign w_lbyte = 8'(dmem.rdata >> {w_off, 3'b000});
  assign w_lhalf = 16'(dmem.rdata >> {w_off[1], 4'b0000});

  always_comb begin
    w_ldata = dmem.rdata;
    if (w_is_byte)
      w_ldata = {{24{~w_unsigned & w_lbyte[7]}}, w_lbyte};
    else if (w_is_half)
      w_ldata = {{16{~w_unsigned & w_lhalf[15]}}, w_lhalf};
  end

  always_comb begin
    w_state_nxt  = r_state;
    dmem.req     = 1'b0;
    dmem.we      = 1'b0;
    dmem.be      = 4'b0000;
    rf_we        = 1'b0;
    rf_waddr     = wb_dest_reg_sel;
    rf_wdata     = wb_result;
    stall_read   = 1'b0;
    misalign_err = 1'b0;
    bus_err      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_mem_op) begin
          rf_we = wb_alu_to_reg & w_rd_nz;
        end else if (w_misalign) begin
          misalign_err = 1'b1;
        end else begin
          dmem.req = 1'b1;
          dmem.we  = w_store;
          dmem.be  = w_store ? w_st_be : 4'b1111;
          if (!dmem.ready) begin
            w_state_nxt = S_REQ;
            stall_read  = 1'b1;
          end else if (w_load) begin
            w_state_nxt = S_RESP;
            stall_read  = 1'b1;
          end
        end
      end
      S_REQ: begin
        dmem.req = 1'b1;
        dmem.we  = w_store;
        dmem.be  = w_store ? w_st_be : 4'b1111;
        if (dmem.ready) begin
          w_state_nxt = w_load ? S_RESP : S_IDLE;
          stall_read  = w_load;
        end else if (w_timeout) begin
          bus_err     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          stall_read = 1'b1;
        end
      end
      S_RESP: begin
        rf_wdata = w_ldata;
        if (dmem.rvalid) begin
          rf_we       = w_rd_nz;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          bus_err     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          stall_read = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (reset) begin
      w_state_nxt  = S_IDLE;
      dmem.req     = 1'b0;
      dmem.we      = 1'b0;
      dmem.be      = 4'b0000;
      rf_we        = 1'b0;
      stall_read   = 1'b0;
      misalign_err = 1'b0;
      bus_err      = 1'b0;
    end
  end

  // The launching IDLE cycle counts as the first stalled cycle, hence the preset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE)
        r_cnt <= (w_state_nxt != S_IDLE) ? CNT_W'(1) : '0;
      else if (c_TO_EN)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_wb_stage
// Brief    : Directed self-checking bench for mem_wb_stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_result, wb_mem_addr;
  logic        wb_mem_write, wb_mem_to_reg, wb_alu_to_reg;
  logic [4:0]  wb_dest_reg_sel;
  logic [2:0]  mem_alu_operation;

  logic        rf_we0, stall0, mis0, berr0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic        rf_we1, stall1, mis1, berr1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;

  int total = 0;
  int bad   = 0;

  mem_wb_stage_if d0 ();
  mem_wb_stage_if d1 ();

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .wb_result(wb_result), .wb_mem_addr(wb_mem_addr),
    .wb_mem_write(wb_mem_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_to_reg(wb_alu_to_reg), .wb_dest_reg_sel(wb_dest_reg_sel),
    .mem_alu_operation(mem_alu_operation), .dmem(d0),
    .rf_we(rf_we0), .rf_waddr(waddr0), .rf_wdata(wdata0),
    .stall_read(stall0), .misalign_err(mis0), .bus_err(berr0)
  );

  mem_wb_stage #(.DMEM_TIMEOUT(4), .CNT_W(8)) dut_to (
    .clk(clk), .reset(reset), .wb_result(wb_result), .wb_mem_addr(wb_mem_addr),
    .wb_mem_write(wb_mem_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_to_reg(wb_alu_to_reg), .wb_dest_reg_sel(wb_dest_reg_sel),
    .mem_alu_operation(mem_alu_operation), .dmem(d1),
    .rf_we(rf_we1), .rf_waddr(waddr1), .rf_wdata(wdata1),
    .stall_read(stall1), .misalign_err(mis1), .bus_err(berr1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    wb_result = '0; wb_mem_addr = '0; wb_mem_write = 0; wb_mem_to_reg = 0;
    wb_alu_to_reg = 0; wb_dest_reg_sel = '0; mem_alu_operation = '0;
    d0.ready = 0; d0.rvalid = 0; d0.rdata = '0;
    d1.ready = 0; d1.rvalid = 0; d1.rdata = '0;
  endtask

  task automatic test_reset;
    reset = 1; set_idle();
    wb_mem_write = 1; mem_alu_operation = 3'b010; wb_mem_addr = 32'h100;
    wb_alu_to_reg = 1; wb_dest_reg_sel = 5; d0.ready = 1;
    #1;
    total++; if (d0.req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", d0.req); end
    total++; if (rf_we0 !== 1'b0) begin bad++; $display("FAIL rst_rfwe got=%b want=0", rf_we0); end
    total++; if ({stall0, mis0, berr0} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {stall0, mis0, berr0}); end
    total++; if ({d1.req, stall1} !== 2'b00) begin bad++; $display("FAIL rst_to got=%b want=00", {d1.req, stall1}); end
    tick(); tick();
    reset = 0; set_idle();
  endtask

  task automatic test_alu;
    wb_alu_to_reg = 1; wb_dest_reg_sel = 5; wb_result = 32'h1234;
    #1;
    total++; if (rf_we0 !== 1'b1) begin bad++; $display("FAIL alu_we got=%b want=1", rf_we0); end
    total++; if (waddr0 !== 5'd5) begin bad++; $display("FAIL alu_waddr got=%0d want=5", waddr0); end
    total++; if (wdata0 !== 32'h1234) begin bad++; $display("FAIL alu_wdata got=%h want=00001234", wdata0); end
    total++; if ({stall0, d0.req} !== 2'b00) begin bad++; $display("FAIL alu_stall_req got=%b want=00", {stall0, d0.req}); end
    tick();
    wb_dest_reg_sel = 0;
    #1;
    total++; if (rf_we0 !== 1'b0) begin bad++; $display("FAIL alu_rd0 got=%b want=0", rf_we0); end
    tick(); set_idle();
  endtask

  task automatic test_store;
    wb_mem_write = 1; mem_alu_operation = 3'b000; wb_mem_addr = 32'h103;
    wb_result = 32'hAB; d0.ready = 1;
    #1;
    total++; if (d0.addr !== 32'h100) begin bad++; $display("FAIL sb_addr got=%h want=00000100", d0.addr); end
    total++; if (d0.be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b want=1000", d0.be); end
    total++; if (d0.wdata !== 32'hABABABAB) begin bad++; $display("FAIL sb_wdata got=%h want=abababab", d0.wdata); end
    total++; if ({d0.req, d0.we, stall0} !== 3'b110) begin bad++; $display("FAIL sb_ctl got=%b want=110", {d0.req, d0.we, stall0}); end
    tick();
    mem_alu_operation = 3'b001; wb_mem_addr = 32'h102; wb_result = 32'h1234CDEF; d0.ready = 0;
    #1;
    total++; if ({d0.req, stall0} !== 2'b11) begin bad++; $display("FAIL sh_wait got=%b want=11", {d0.req, stall0}); end
    total++; if ({d0.be, d0.wdata} !== {4'b1100, 32'hCDEFCDEF}) begin bad++; $display("FAIL sh_lane got=%b/%h want=1100/cdefcdef", d0.be, d0.wdata); end
    tick();
    d0.ready = 1;
    #1;
    total++; if ({d0.req, d0.be, stall0} !== {1'b1, 4'b1100, 1'b0}) begin bad++; $display("FAIL sh_req_done got=%b want=111000", {d0.req, d0.be, stall0}); end
    tick(); set_idle();
  endtask

  task automatic test_load;
    logic [2:0]  f3  [2] = '{3'b000, 3'b100};
    logic [31:0] exp [2] = '{32'hFFFFFFFF, 32'h000000FF};
    for (int k = 0; k < 2; k++) begin
      set_idle();
      wb_mem_to_reg = 1; wb_alu_to_reg = 1; wb_dest_reg_sel = 7;
      wb_mem_addr = 32'h102; mem_alu_operation = f3[k]; d0.ready = 1;
      #1;
      total++; if ({d0.req, d0.we, d0.be, stall0} !== {2'b10, 4'b1111, 1'b1}) begin bad++; $display("FAIL ld%0d_c0 got=%b want=1011111", k, {d0.req, d0.we, d0.be, stall0}); end
      tick();
      d0.ready = 0;
      for (int c = 1; c < 3; c++) begin
        #1;
        total++; if ({d0.req, stall0, rf_we0} !== 3'b010) begin bad++; $display("FAIL ld%0d_c%0d got=%b want=010", k, c, {d0.req, stall0, rf_we0}); end
        tick();
      end
      d0.rvalid = 1; d0.rdata = 32'h00FF7F00;
      #1;
      total++; if ({stall0, rf_we0, waddr0} !== {2'b01, 5'd7}) begin bad++; $display("FAIL ld%0d_c3 got=%b want=0100111", k, {stall0, rf_we0, waddr0}); end
      total++; if (wdata0 !== exp[k]) begin bad++; $display("FAIL ld%0d_data got=%h want=%h", k, wdata0, exp[k]); end
      tick();
    end
    set_idle();
  endtask

  task automatic test_misalign;
    wb_mem_to_reg = 1; wb_alu_to_reg = 1; wb_dest_reg_sel = 7;
    mem_alu_operation = 3'b001; wb_mem_addr = 32'h101; d0.ready = 1;
    #1;
    total++; if ({mis0, d0.req, rf_we0, stall0} !== 4'b1000) begin bad++; $display("FAIL lh_mis got=%b want=1000", {mis0, d0.req, rf_we0, stall0}); end
    tick(); set_idle();
    #1;
    total++; if (mis0 !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b want=0", mis0); end
    wb_mem_write = 1; mem_alu_operation = 3'b010; wb_mem_addr = 32'h102; d0.ready = 1;
    #1;
    total++; if ({mis0, d0.req} !== 2'b10) begin bad++; $display("FAIL sw_mis got=%b want=10", {mis0, d0.req}); end
    tick(); set_idle();
  endtask

  task automatic test_timeout;
    reset = 1; set_idle(); tick(); reset = 0;
    wb_mem_to_reg = 1; wb_alu_to_reg = 1; wb_dest_reg_sel = 3;
    mem_alu_operation = 3'b010; wb_mem_addr = 32'h200;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if ({berr1, stall1, rf_we1} !== {c == 3, c != 3, 1'b0}) begin bad++; $display("FAIL to_c%0d got=%b want=%b", c, {berr1, stall1, rf_we1}, {c == 3, c != 3, 1'b0}); end
      if (c == 3) begin
        total++; if ({berr0, stall0} !== 2'b01) begin bad++; $display("FAIL to_long got=%b want=01", {berr0, stall0}); end
      end
      tick();
    end
    set_idle(); wb_alu_to_reg = 1; wb_dest_reg_sel = 9; wb_result = 32'h55;
    #1;
    total++; if ({rf_we1, stall1, berr1, d1.req} !== 4'b1000) begin bad++; $display("FAIL to_idle got=%b want=1000", {rf_we1, stall1, berr1, d1.req}); end
    tick(); set_idle();
  endtask

  task automatic test_reset_mid;
    reset = 1; set_idle(); tick(); reset = 0;
    wb_mem_to_reg = 1; wb_alu_to_reg = 1; wb_dest_reg_sel = 6;
    mem_alu_operation = 3'b010; wb_mem_addr = 32'h300; d0.ready = 1;
    tick();
    d0.ready = 0;
    #1;
    total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL rm_resp got=%b want=1", stall0); end
    reset = 1; tick(); reset = 0;
    set_idle(); wb_dest_reg_sel = 6; d0.rvalid = 1; d0.rdata = 32'hDEADBEEF;
    #1;
    total++; if ({rf_we0, stall0, d0.req} !== 3'b000) begin bad++; $display("FAIL rm_rvalid got=%b want=000", {rf_we0, stall0, d0.req}); end
    tick();
    wb_alu_to_reg = 1; wb_dest_reg_sel = 4; wb_result = 32'h77;
    #1;
    total++; if ({rf_we0, stall0, wdata0} !== {2'b10, 32'h77}) begin bad++; $display("FAIL rm_idle got=%b/%h want=10/00000077", {rf_we0, stall0}, wdata0); end
    tick(); set_idle();
  endtask

  task automatic test_back_to_back;
    wb_mem_write = 1; wb_mem_to_reg = 1; wb_alu_to_reg = 1; wb_dest_reg_sel = 8;
    mem_alu_operation = 3'b010; wb_mem_addr = 32'h40; wb_result = 32'hCAFEF00D; d0.ready = 1;
    #1;
    total++; if ({d0.we, rf_we0, stall0, d0.be} !== {3'b100, 4'b1111}) begin bad++; $display("FAIL ls_both got=%b want=1001111", {d0.we, rf_we0, stall0, d0.be}); end
    total++; if (d0.wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL ls_wdata got=%h want=cafef00d", d0.wdata); end
    tick();
    set_idle(); wb_alu_to_reg = 1; wb_dest_reg_sel = 8; wb_result = 32'h99;
    #1;
    total++; if ({rf_we0, stall0, d0.req, wdata0} !== {3'b100, 32'h99}) begin bad++; $display("FAIL b2b_alu got=%b/%h want=100/00000099", {rf_we0, stall0, d0.req}, wdata0); end
    tick();
    set_idle(); wb_mem_write = 1; mem_alu_operation = 3'b000; wb_mem_addr = 32'h41;
    wb_result = 32'h12; d0.ready = 1;
    #1;
    total++; if ({d0.be, d0.wdata, stall0} !== {4'b0010, 32'h12121212, 1'b0}) begin bad++; $display("FAIL b2b_sb got=%b/%h want=0010/12121212", d0.be, d0.wdata); end
    tick(); set_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; set_idle();
    tick();
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
